// File: rtl/mem_arb2_if.sv
// Bundle for the two-port memory arbiter: two requester ports, the shared memory
// request port and the memory response input.
interface mem_arb2_if;
    logic        p0_valid;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [3:0]  p0_do_write;
    logic        p0_ack;
    logic        p0_rsp_valid;
    logic [31:0] p0_rsp_data;

    logic        p1_valid;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_do_write;
    logic        p1_ack;
    logic        p1_rsp_valid;
    logic [31:0] p1_rsp_data;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_do_write;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    // Arbiter side
    modport slave (
        input  p0_valid, p0_addr, p0_wdata, p0_do_write,
        input  p1_valid, p1_addr, p1_wdata, p1_do_write,
        output p0_ack, p0_rsp_valid, p0_rsp_data,
        output p1_ack, p1_rsp_valid, p1_rsp_data,
        output mem_valid, mem_addr, mem_wdata, mem_do_write,
        input  mem_rsp_valid, mem_rsp_data
    );

    // Requesters plus memory side
    modport master (
        output p0_valid, p0_addr, p0_wdata, p0_do_write,
        output p1_valid, p1_addr, p1_wdata, p1_do_write,
        input  p0_ack, p0_rsp_valid, p0_rsp_data,
        input  p1_ack, p1_rsp_valid, p1_rsp_data,
        input  mem_valid, mem_addr, mem_wdata, mem_do_write,
        output mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/mem_arb2.sv
// Two-requester arbiter onto one fixed-latency memory port; an ownership shift
// register routes each memory response back to the port that issued the request.
module mem_arb2 #(
    parameter int LATENCY     = 1,
    parameter int ROUND_ROBIN = 1
) (
    input  logic      clk,
    input  logic      reset,
    mem_arb2_if.slave bus
);
    localparam logic [2:0] DRAIN_INIT = 3'(LATENCY);

    logic               last_grant_q, last_grant_d;
    logic [LATENCY-1:0] own_vld_q;
    logic [LATENCY-1:0] own_port_q;
    logic [2:0]         drain_q, drain_d;
    logic               sticky_orphan_q, sticky_orphan_d;
    logic               gnt0, gnt1, mem_vld;
    logic               tail_vld, tail_port, rsp_hit;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (bus.p0_valid && bus.p1_valid) begin
                if ((ROUND_ROBIN != 0) && !last_grant_q) gnt1 = 1'b1;
                else                                    gnt0 = 1'b1;
            end else begin
                gnt0 = bus.p0_valid;
                gnt1 = bus.p1_valid;
            end
        end
    end

    assign mem_vld          = gnt0 | gnt1;
    assign bus.p0_ack       = gnt0;
    assign bus.p1_ack       = gnt1;
    assign bus.mem_valid    = mem_vld;
    assign bus.mem_addr     = gnt0 ? bus.p0_addr     : (gnt1 ? bus.p1_addr     : '0);
    assign bus.mem_wdata    = gnt0 ? bus.p0_wdata    : (gnt1 ? bus.p1_wdata    : '0);
    assign bus.mem_do_write = gnt0 ? bus.p0_do_write : (gnt1 ? bus.p1_do_write : '0);

    assign tail_vld  = own_vld_q[LATENCY-1];
    assign tail_port = own_port_q[LATENCY-1];
    assign rsp_hit   = !reset && bus.mem_rsp_valid && tail_vld;

    assign bus.p0_rsp_valid = rsp_hit && !tail_port;
    assign bus.p1_rsp_valid = rsp_hit &&  tail_port;
    assign bus.p0_rsp_data  = (rsp_hit && !tail_port) ? bus.mem_rsp_data : '0;
    assign bus.p1_rsp_data  = (rsp_hit &&  tail_port) ? bus.mem_rsp_data : '0;

    // After reset, responses to requests issued before it may still be in flight
    // for up to LATENCY cycles; they are dropped silently rather than flagged.
    always_comb begin
        last_grant_d    = mem_vld ? gnt1 : last_grant_q;
        drain_d         = (drain_q != 3'd0) ? (drain_q - 3'd1) : 3'd0;
        sticky_orphan_d = sticky_orphan_q |
                          (bus.mem_rsp_valid && !tail_vld && (drain_q == 3'd0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q    <= 1'b1;
            own_vld_q       <= '0;
            own_port_q      <= '0;
            drain_q         <= DRAIN_INIT;
            sticky_orphan_q <= 1'b0;
        end else begin
            last_grant_q    <= last_grant_d;
            drain_q         <= drain_d;
            sticky_orphan_q <= sticky_orphan_d;
            own_vld_q[0]    <= mem_vld;
            own_port_q[0]   <= gnt1;
            for (int i = 1; i < LATENCY; i++) begin
                own_vld_q[i]  <= own_vld_q[i-1];
                own_port_q[i] <= own_port_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: round-robin DUT (LATENCY=3) and fixed-priority DUT (LATENCY=1),
// each with a fixed-latency memory model and a response scoreboard.
module tb_mem_arb2;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic exp_last_a = 1'b1;
    logic inj_a = 1'b0;
    exp_t qa[$];
    exp_t qb[$];

    mem_arb2_if ia();
    mem_arb2_if ib();

    mem_arb2 #(.LATENCY(LAT_A), .ROUND_ROBIN(1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    mem_arb2 #(.LATENCY(LAT_B), .ROUND_ROBIN(0)) dut_b (.clk(clk), .reset(reset), .bus(ib));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdl(input logic [31:0] addr);
        if (addr == 32'h0001_0040) return 32'hDEAD_BEEF;
        return (addr ^ 32'h5A5A_0000) + 32'h1;
    endfunction

    // Memory models: answer exactly LATENCY cycles after mem_valid, ignoring arbiter reset
    logic [LAT_A-1:0]       mpa_v = '0;
    logic [LAT_A-1:0][31:0] mpa_d = '0;
    logic                   mpb_v = 1'b0;
    logic [31:0]            mpb_d = '0;
    always @(posedge clk) begin
        mpa_v <= {mpa_v[LAT_A-2:0], ia.mem_valid};
        mpa_d <= {mpa_d[LAT_A-2:0], mdl(ia.mem_addr)};
        mpb_v <= ib.mem_valid;
        mpb_d <= mdl(ib.mem_addr);
    end
    assign ia.mem_rsp_valid = mpa_v[LAT_A-1] | inj_a;
    assign ia.mem_rsp_data  = mpa_v[LAT_A-1] ? mpa_d[LAT_A-1] : 32'h0BAD_0BAD;
    assign ib.mem_rsp_valid = mpb_v;
    assign ib.mem_rsp_data  = mpb_v ? mpb_d : 32'h0BAD_0BAD;

    // Scoreboard for DUT A
    always @(negedge clk) begin
        exp_t e;
        int   port;
        logic [31:0] data;
        checks++;
        if (ia.p0_rsp_valid || ia.p1_rsp_valid) begin
            port = ia.p1_rsp_valid ? 1 : 0;
            data = port == 1 ? ia.p1_rsp_data : ia.p0_rsp_data;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL rsp_a_unexpected cyc=%0d p0=%b p1=%b data=%h required none", cyc, ia.p0_rsp_valid, ia.p1_rsp_valid, data);
            end else begin
                e = qa.pop_front();
                if ((ia.p0_rsp_valid && ia.p1_rsp_valid) || port != e.port || data !== e.data || cyc != e.due ||
                    (port == 1 ? ia.p0_rsp_data : ia.p1_rsp_data) !== 32'h0) begin
                    errors++;
                    $display("FAIL rsp_a cyc=%0d port=%0d data=%h required cyc=%0d port=%0d data=%h", cyc, port, data, e.due, e.port, e.data);
                end
            end
        end else if (ia.p0_rsp_data !== 32'h0 || ia.p1_rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL rsp_a_idle_data cyc=%0d d0=%h d1=%h required 0", cyc, ia.p0_rsp_data, ia.p1_rsp_data);
        end else if (qa.size() > 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            errors++;
            $display("FAIL rsp_a_missing cyc=%0d got none required port=%0d data=%h", cyc, e.port, e.data);
        end
    end

    // Scoreboard for DUT B
    always @(negedge clk) begin
        exp_t e;
        int   port;
        logic [31:0] data;
        if (ib.p0_rsp_valid || ib.p1_rsp_valid) begin
            checks++;
            port = ib.p1_rsp_valid ? 1 : 0;
            data = port == 1 ? ib.p1_rsp_data : ib.p0_rsp_data;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL rsp_b_unexpected cyc=%0d data=%h required none", cyc, data);
            end else begin
                e = qb.pop_front();
                if ((ib.p0_rsp_valid && ib.p1_rsp_valid) || port != e.port || data !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp_b cyc=%0d port=%0d data=%h required cyc=%0d port=%0d data=%h", cyc, port, data, e.due, e.port, e.data);
                end
            end
        end else if (qb.size() > 0 && qb[0].due <= cyc) begin
            checks++;
            e = qb.pop_front();
            errors++;
            $display("FAIL rsp_b_missing cyc=%0d got none required port=%0d data=%h", cyc, e.port, e.data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int port, input logic [31:0] addr);
        exp_t e;
        e.port = port;
        e.data = mdl(addr);
        e.due  = cyc + LAT_A;
        qa.push_back(e);
    endtask

    task automatic test_reset();
        ia.p0_valid = 1'b1; ia.p1_valid = 1'b1;
        ia.p0_addr = 32'h1234_5678; ia.p1_addr = 32'h8765_4321;
        ib.p0_valid = 1'b1; ib.p1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ia.p0_ack !== 1'b0 || ia.p1_ack !== 1'b0 || ib.p0_ack !== 1'b0 || ib.p1_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_acks got a=%b%b b=%b%b required 0000", ia.p0_ack, ia.p1_ack, ib.p0_ack, ib.p1_ack);
        end
        checks++;
        if (ia.mem_valid !== 1'b0 || ia.mem_addr !== 32'h0 || ia.mem_wdata !== 32'h0 || ia.mem_do_write !== 4'h0) begin
            errors++;
            $display("FAIL reset_mem got valid=%b addr=%h required 0", ia.mem_valid, ia.mem_addr);
        end
        checks++;
        if (dut_a.last_grant_q !== 1'b1 || dut_a.sticky_orphan_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got last_grant=%b sticky=%b required 1 0", dut_a.last_grant_q, dut_a.sticky_orphan_q);
        end
        ia.p0_valid = 1'b0; ia.p1_valid = 1'b0;
        ib.p0_valid = 1'b0; ib.p1_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        ia.p1_valid = 1'b1; ia.p1_addr = 32'h0001_0040; ia.p1_do_write = 4'h0;
        @(negedge clk);
        checks++;
        if (ia.p1_ack !== 1'b1 || ia.p0_ack !== 1'b0 || ia.mem_addr !== 32'h0001_0040 || ia.mem_do_write !== 4'h0) begin
            errors++;
            $display("FAIL single_read_ack got ack=%b%b addr=%h required 01 00010040", ia.p0_ack, ia.p1_ack, ia.mem_addr);
        end
        push_a(1, 32'h0001_0040);
        exp_last_a = 1'b1;
        step();
        ia.p1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ia.mem_valid !== 1'b0 || ia.mem_addr !== 32'h0 || ia.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL idle_mem got valid=%b addr=%h required 0", ia.mem_valid, ia.mem_addr);
        end
        repeat (LAT_A + 1) step();
    endtask

    task automatic test_contention();
        int n0 = 0;
        int n1 = 0;
        logic exp1;
        logic [31:0] a0, a1;
        for (int k = 0; k < 4; k++) begin
            a0 = 32'h0000_1000 + 32'(n0 * 4);
            a1 = 32'h0000_2000 + 32'(n1 * 4);
            ia.p0_valid = 1'b1; ia.p0_addr = a0; ia.p0_do_write = 4'h0;
            ia.p1_valid = 1'b1; ia.p1_addr = a1; ia.p1_do_write = 4'h0;
            exp1 = ~exp_last_a;
            @(negedge clk);
            checks++;
            if (ia.p0_ack !== ~exp1 || ia.p1_ack !== exp1 || ia.mem_addr !== (exp1 ? a1 : a0)) begin
                errors++;
                $display("FAIL contention_%0d got ack=%b%b addr=%h required ack=%b%b addr=%h", k, ia.p0_ack, ia.p1_ack, ia.mem_addr, ~exp1, exp1, exp1 ? a1 : a0);
            end
            push_a(exp1 ? 1 : 0, exp1 ? a1 : a0);
            exp_last_a = exp1;
            if (exp1) n1++; else n0++;
            step();
        end
        ia.p0_valid = 1'b0; ia.p1_valid = 1'b0;
        repeat (LAT_A + 2) step();
    endtask

    task automatic test_write();
        ia.p1_valid = 1'b1; ia.p1_addr = 32'h0002_FFF8; ia.p1_wdata = 32'h41; ia.p1_do_write = 4'b1111;
        @(negedge clk);
        checks++;
        if (ia.p1_ack !== 1'b1 || ia.mem_do_write !== 4'b1111 || ia.mem_wdata !== 32'h41 || ia.mem_addr !== 32'h0002_FFF8) begin
            errors++;
            $display("FAIL write got ack=%b we=%b wdata=%h addr=%h required 1 1111 00000041 0002fff8", ia.p1_ack, ia.mem_do_write, ia.mem_wdata, ia.mem_addr);
        end
        push_a(1, 32'h0002_FFF8);
        exp_last_a = 1'b1;
        step();
        ia.p1_valid = 1'b0; ia.p1_do_write = 4'h0;
        repeat (LAT_A + 1) step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr, wd;
        logic [3:0]  we;
        for (int k = 0; k < 6; k++) begin
            addr = $urandom & 32'hFFFF_FFFC;
            wd   = $urandom;
            we   = 4'($urandom_range(0, 15));
            ia.p0_valid = (k % 2 == 0); ia.p1_valid = (k % 2 == 1);
            if (k % 2 == 0) begin ia.p0_addr = addr; ia.p0_wdata = wd; ia.p0_do_write = we; end
            else            begin ia.p1_addr = addr; ia.p1_wdata = wd; ia.p1_do_write = we; end
            @(negedge clk);
            checks++;
            if (ia.p0_ack !== (k % 2 == 0) || ia.p1_ack !== (k % 2 == 1) || ia.mem_addr !== addr ||
                ia.mem_wdata !== wd || ia.mem_do_write !== we) begin
                errors++;
                $display("FAIL b2b_%0d got ack=%b%b addr=%h wd=%h we=%b required port=%0d addr=%h wd=%h we=%b", k, ia.p0_ack, ia.p1_ack, ia.mem_addr, ia.mem_wdata, ia.mem_do_write, k % 2, addr, wd, we);
            end
            push_a(k % 2, addr);
            exp_last_a = (k % 2 == 1);
            step();
        end
        ia.p0_valid = 1'b0; ia.p1_valid = 1'b0;
        repeat (LAT_A + 2) step();
    endtask

    task automatic test_midflight_reset();
        ia.p0_valid = 1'b1; ia.p0_addr = 32'h0000_3000; ia.p0_do_write = 4'h0;
        @(negedge clk);
        checks++;
        if (ia.p0_ack !== 1'b1) begin
            errors++;
            $display("FAIL midreset_grant got p0_ack=%b required 1", ia.p0_ack);
        end
        step();
        ia.p0_valid = 1'b0;
        ia.p1_valid = 1'b1; ia.p1_addr = 32'h0000_3100;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ia.p1_ack !== 1'b0 || ia.mem_valid !== 1'b0 || ia.mem_addr !== 32'h0 || ia.p0_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got ack=%b mem_valid=%b addr=%h required 0", ia.p1_ack, ia.mem_valid, ia.mem_addr);
        end
        ia.p1_valid = 1'b0;
        step();
        reset = 1'b0;
        exp_last_a = 1'b1;
        repeat (LAT_A + 2) begin
            @(negedge clk);
            checks++;
            if (ia.p0_rsp_valid !== 1'b0 || ia.p1_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_rsp got rsp=%b%b required 00", ia.p0_rsp_valid, ia.p1_rsp_valid);
            end
            step();
        end
        checks++;
        if (dut_a.sticky_orphan_q !== 1'b0) begin
            errors++;
            $display("FAIL midreset_sticky got %b required 0", dut_a.sticky_orphan_q);
        end
        ia.p0_valid = 1'b1; ia.p0_addr = 32'h0000_3200;
        ia.p1_valid = 1'b1; ia.p1_addr = 32'h0000_3300;
        @(negedge clk);
        checks++;
        if (ia.p0_ack !== 1'b1 || ia.p1_ack !== 1'b0) begin
            errors++;
            $display("FAIL midreset_first_contention got ack=%b%b required 10", ia.p0_ack, ia.p1_ack);
        end
        push_a(0, 32'h0000_3200);
        step();
        ia.p0_valid = 1'b0;
        @(negedge clk);
        push_a(1, 32'h0000_3300);
        step();
        ia.p1_valid = 1'b0;
        exp_last_a = 1'b1;
        repeat (LAT_A + 2) step();
    endtask

    task automatic test_orphan();
        inj_a = 1'b1;
        @(negedge clk);
        checks++;
        if (ia.p0_rsp_valid !== 1'b0 || ia.p1_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL orphan_rsp got rsp=%b%b required 00", ia.p0_rsp_valid, ia.p1_rsp_valid);
        end
        step();
        inj_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dut_a.sticky_orphan_q !== 1'b1) begin
                errors++;
                $display("FAIL orphan_sticky got %b required 1", dut_a.sticky_orphan_q);
            end
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_a.sticky_orphan_q !== 1'b0) begin
            errors++;
            $display("FAIL orphan_clear got %b required 0", dut_a.sticky_orphan_q);
        end
        step();
        reset = 1'b0;
        exp_last_a = 1'b1;
        repeat (LAT_A + 1) step();
    endtask

    task automatic test_fixed_priority();
        exp_t e;
        logic [31:0] a0;
        ib.p1_valid = 1'b1; ib.p1_addr = 32'h0000_5000; ib.p1_do_write = 4'h0;
        for (int k = 0; k < 5; k++) begin
            a0 = 32'h0000_4000 + 32'(k * 4);
            ib.p0_valid = 1'b1; ib.p0_addr = a0; ib.p0_do_write = 4'h0;
            @(negedge clk);
            checks++;
            if (ib.p0_ack !== 1'b1 || ib.p1_ack !== 1'b0 || ib.mem_addr !== a0) begin
                errors++;
                $display("FAIL fixed_prio_%0d got ack=%b%b addr=%h required ack=10 addr=%h", k, ib.p0_ack, ib.p1_ack, ib.mem_addr, a0);
            end
            e.port = 0; e.data = mdl(a0); e.due = cyc + LAT_B;
            qb.push_back(e);
            step();
        end
        ib.p0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ib.p1_ack !== 1'b1 || ib.mem_addr !== 32'h0000_5000) begin
            errors++;
            $display("FAIL fixed_prio_p1 got ack=%b addr=%h required 1 00005000", ib.p1_ack, ib.mem_addr);
        end
        e.port = 1; e.data = mdl(32'h0000_5000); e.due = cyc + LAT_B;
        qb.push_back(e);
        step();
        ib.p1_valid = 1'b0;
        repeat (LAT_B + 2) step();
    endtask

    initial begin
        ia.p0_valid = 1'b0; ia.p0_addr = '0; ia.p0_wdata = '0; ia.p0_do_write = '0;
        ia.p1_valid = 1'b0; ia.p1_addr = '0; ia.p1_wdata = '0; ia.p1_do_write = '0;
        ib.p0_valid = 1'b0; ib.p0_addr = '0; ib.p0_wdata = '0; ib.p0_do_write = '0;
        ib.p1_valid = 1'b0; ib.p1_addr = '0; ib.p1_wdata = '0; ib.p1_do_write = '0;
        step();
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_back_to_back();
        test_midflight_reset();
        test_orphan();
        test_fixed_priority();
        repeat (4) step();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain got pending a=%0d b=%0d required 0 0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout at cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
